rvfi_trace_buffer: RTL and testbench

Synthesizable, multi-port successor to the simulation-only RVFI tracer. Each cycle it collects up to NR_COMMIT_PORTS retired or trapping instructions from the RVFI bus and packs them in port order into a circular trace FIFO. It drains the FIFO one record per cycle over a valid/ready stream toward a trace sink (DMA, UART bridge or bench).
It also counts cycles and retirements, detects an M-mode ECALL halt and a programmable timeout, and reports overflow instead of silently losing records.

---
 rtl/rvfi_trace_pkg.sv | 52 +++++
 rtl/rvfi_trace_compact.sv | 48 ++++
 rtl/rvfi_trace_buffer.sv | 125 ++++++++++++
 tb/tb_rvfi_trace_buffer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_trace_pkg.sv
// Shared types for the RVFI trace buffer: commit-port record, trace record,
// control states and the M-mode ECALL encoding.
package rvfi_trace_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned TRACE_TS_W = 32;

  localparam logic [31:0] ECALL_INSN = 32'h0000_0073;
  localparam logic [1:0]  PRIV_M     = 2'b11;

  typedef struct packed {
    logic            valid;
    logic            trap;
    logic [XLEN-1:0] pc_rdata;
    logic [31:0]     insn;
    logic [1:0]      mode;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] cause;
  } rvfi_instr_t;

  typedef struct packed {
    logic [63:0]           pc;
    logic [31:0]           insn;
    logic [TRACE_TS_W-1:0] timestamp;
    logic [XLEN-1:0]       rd_wdata;
    logic [4:0]            rd_addr;
    logic [1:0]            mode;
    logic                  trap;
    logic [3:0]            cause;
  } trace_rec_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} trace_state_e;

  function automatic trace_rec_t to_record(rvfi_instr_t r, logic [TRACE_TS_W-1:0] ts);
    trace_rec_t t;
    t.pc        = {{(64-XLEN){r.pc_rdata[XLEN-1]}}, r.pc_rdata};
    t.insn      = r.insn;
    t.timestamp = ts;
    t.rd_wdata  = r.rd_wdata;
    t.rd_addr   = r.rd_addr;
    t.mode      = r.mode;
    t.trap      = r.trap;
    t.cause     = r.cause[3:0];
    return t;
  endfunction

  function automatic logic is_m_ecall(rvfi_instr_t r);
    return r.valid && (r.insn == ECALL_INSN) && (r.mode == PRIV_M);
  endfunction

endpackage

// File: rtl/rvfi_trace_compact.sv
// Combinational packer: scans commit ports in ascending order and compacts
// qualifying entries into consecutive slots, stopping after an M-mode ECALL.
module rvfi_trace_compact
  import rvfi_trace_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  localparam int unsigned CW = $clog2(NR_COMMIT_PORTS + 1)
) (
  input  logic                                 capture,
  input  logic [TRACE_TS_W-1:0]                timestamp,
  input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]    rvfi,
  output trace_rec_t  [NR_COMMIT_PORTS-1:0]    entries,
  output logic [CW-1:0]                        count,
  output logic [CW-1:0]                        valid_count,
  output logic                                 ecall
);

  logic unused_cause_hi;

  always_comb begin
    int n;
    int nv;
    entries = '0;
    ecall   = 1'b0;
    n       = 0;
    nv      = 0;
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      // Once an ECALL is taken, later ports in the same cycle are discarded.
      if (capture && !ecall && (rvfi[i].valid || rvfi[i].trap)) begin
        for (int j = 0; j < int'(NR_COMMIT_PORTS); j++) begin
          if (j == n) entries[j] = to_record(rvfi[i], timestamp);
        end
        n = n + 1;
        if (rvfi[i].valid) nv = nv + 1;
        if (is_m_ecall(rvfi[i])) ecall = 1'b1;
      end
    end
    count       = CW'(n);
    valid_count = CW'(nv);
  end

  always_comb begin
    unused_cause_hi = 1'b0;
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++)
      unused_cause_hi = unused_cause_hi ^ (^rvfi[i].cause[XLEN-1:4]);
  end

endmodule

// File: rtl/rvfi_trace_buffer.sv
// Multi-port RVFI trace capture into a circular FIFO drained over valid/ready,
// with drop accounting, retirement/cycle counters and ECALL/timeout halt.
//   state  | meaning
//   RUN    | capturing commits into the FIFO
//   DRAIN  | halt requested, no capture, waiting for FIFO to empty
//   HALTED | FIFO drained after halt request; halt_o asserted
module rvfi_trace_buffer
  import rvfi_trace_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned DROP_W          = 16,
  parameter int unsigned TS_W            = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              en_i,
  input  logic                              clear_i,
  input  logic [TS_W-1:0]                   timeout_i,
  input  rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
  output trace_rec_t                        trace_o,
  output logic                              trace_valid_o,
  input  logic                              trace_ready_i,
  output logic [$clog2(DEPTH):0]            level_o,
  output logic                              overflow_o,
  output logic [DROP_W-1:0]                 drop_cnt_o,
  output logic [63:0]                       retired_cnt_o,
  output logic [TS_W-1:0]                   cycle_o,
  output logic                              halt_o,
  output logic                              timeout_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(NR_COMMIT_PORTS + 1);

  trace_rec_t                       mem [DEPTH];
  logic [LW-1:0]                    wr_cnt, rd_cnt, free;
  logic [AW-1:0]                    wr_ptr, rd_ptr;
  trace_state_e                     state;
  trace_rec_t [NR_COMMIT_PORTS-1:0] entries;
  logic [CW-1:0]                    k, k_valid;
  logic                             ecall, push, pop, timeout_hit;
  logic [DROP_W:0]                  drop_sum;

  rvfi_trace_compact #(.NR_COMMIT_PORTS(NR_COMMIT_PORTS)) u_compact (
    .capture     (en_i && (state == RUN)),
    .timestamp   (TRACE_TS_W'(cycle_o)),
    .rvfi        (rvfi_i),
    .entries     (entries),
    .count       (k),
    .valid_count (k_valid),
    .ecall       (ecall)
  );

  assign wr_ptr        = wr_cnt[AW-1:0];
  assign rd_ptr        = rd_cnt[AW-1:0];
  assign level_o       = wr_cnt - rd_cnt;
  assign trace_valid_o = (level_o != '0);
  assign trace_o       = trace_valid_o ? mem[rd_ptr] : '0;
  // Free space is judged before this cycle's pop so a full FIFO never overwrites its head.
  assign free          = LW'(DEPTH) - level_o;
  assign push          = (k != '0) && (free >= LW'(k));
  assign pop           = trace_valid_o && trace_ready_i;
  assign timeout_hit   = (timeout_i != '0) && (cycle_o >= timeout_i);
  assign drop_sum      = {1'b0, drop_cnt_o} + (DROP_W+1)'(k);

  always_ff @(posedge clk_i) begin
    if (push && !clear_i) begin
      for (int i = 0; i < int'(NR_COMMIT_PORTS); i++)
        if (i < int'(k)) mem[wr_ptr + AW'(i)] <= entries[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      state         <= RUN;
      overflow_o    <= 1'b0;
      drop_cnt_o    <= '0;
      retired_cnt_o <= '0;
      cycle_o       <= '0;
      halt_o        <= 1'b0;
      timeout_o     <= 1'b0;
    end else if (clear_i) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      state      <= RUN;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
      cycle_o    <= '0;
      halt_o     <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      if (cycle_o != '1) cycle_o <= cycle_o + 1'b1;
      if (pop) rd_cnt <= rd_cnt + 1'b1;
      if (push) begin
        wr_cnt        <= wr_cnt + LW'(k);
        retired_cnt_o <= retired_cnt_o + 64'(k_valid);
      end else if (k != '0) begin
        overflow_o <= 1'b1;
        drop_cnt_o <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      end
      case (state)
        RUN: begin
          if (push && ecall) begin
            state <= DRAIN;
          end else if (timeout_hit) begin
            state     <= DRAIN;
            timeout_o <= 1'b1;
          end
        end
        DRAIN: begin
          if (level_o == '0) begin
            state  <= HALTED;
            halt_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Directed and randomized bench for rvfi_trace_buffer against a queue-based
// behavioural model of the trace FIFO, counters and halt sequencing.
module tb_rvfi_trace_buffer;
  import rvfi_trace_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 16;

  logic                   clk = 1'b0;
  logic                   rst_ni = 1'b0;
  logic                   en = 1'b0;
  logic                   clear = 1'b0;
  logic [31:0]            tmo_lim = '0;
  rvfi_instr_t [NR-1:0]   rvfi = '0;
  logic                   ready = 1'b0;
  trace_rec_t             trace_o;
  logic                   trace_valid_o;
  logic [4:0]             level_o;
  logic                   overflow_o;
  logic [15:0]            drop_cnt_o;
  logic [63:0]            retired_cnt_o;
  logic [31:0]            cycle_o;
  logic                   halt_o, timeout_o;

  rvfi_trace_buffer #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH), .DROP_W(16), .TS_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en), .clear_i(clear), .timeout_i(tmo_lim),
    .rvfi_i(rvfi), .trace_o(trace_o), .trace_valid_o(trace_valid_o),
    .trace_ready_i(ready), .level_o(level_o), .overflow_o(overflow_o),
    .drop_cnt_o(drop_cnt_o), .retired_cnt_o(retired_cnt_o), .cycle_o(cycle_o),
    .halt_o(halt_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // behavioural model
  trace_rec_t      q[$];
  int unsigned     m_cyc;
  int              m_drops;
  bit              m_ovf, m_tmo, m_halt, m_run, m_drain;
  longint unsigned m_ret;

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic trace_rec_t mk(rvfi_instr_t r, int unsigned ts);
    trace_rec_t t;
    t.pc        = {{32{r.pc_rdata[31]}}, r.pc_rdata};
    t.insn      = r.insn;
    t.timestamp = ts;
    t.rd_wdata  = r.rd_wdata;
    t.rd_addr   = r.rd_addr;
    t.mode      = r.mode;
    t.trap      = r.trap;
    t.cause     = r.cause[3:0];
    return t;
  endfunction

  function automatic rvfi_instr_t rnd_port(bit v, bit t);
    rvfi_instr_t r;
    r          = '0;
    r.valid    = v;
    r.trap     = t;
    r.pc_rdata = $urandom;
    r.insn     = $urandom | 32'h100;
    r.mode     = 2'($urandom_range(0, 3));
    r.rd_addr  = 5'($urandom);
    r.rd_wdata = $urandom;
    r.cause    = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cyc = 0; m_drops = 0; m_ovf = 0; m_tmo = 0; m_halt = 0;
    m_run = 1; m_drain = 0; m_ret = 0;
  endtask

  task automatic check_all(string tag);
    chk({tag, " level"}, level_o, q.size());
    chk({tag, " valid"}, trace_valid_o, q.size() != 0);
    if (q.size() != 0) chk({tag, " head"}, trace_o, q[0]);
    chk({tag, " overflow"}, overflow_o, m_ovf);
    chk({tag, " drops"}, drop_cnt_o, m_drops);
    chk({tag, " retired"}, retired_cnt_o, m_ret);
    chk({tag, " cycle"}, cycle_o, m_cyc);
    chk({tag, " halt"}, halt_o, m_halt);
    chk({tag, " timeout"}, timeout_o, m_tmo);
  endtask

  // Advance the model by one edge from the current inputs, clock the DUT, compare.
  task automatic step(string tag);
    trace_rec_t grp[$];
    int  pre, nval;
    bit  ec, ok;
    if (clear) begin
      q.delete();
      m_cyc = 0; m_drops = 0; m_ovf = 0; m_tmo = 0; m_halt = 0; m_run = 1; m_drain = 0;
    end else begin
      pre = q.size(); ec = 0; nval = 0;
      if (en && m_run) begin
        for (int i = 0; i < NR; i++) begin
          if (!ec && (rvfi[i].valid || rvfi[i].trap)) begin
            grp.push_back(mk(rvfi[i], m_cyc));
            if (rvfi[i].valid) nval++;
            if (rvfi[i].valid && rvfi[i].insn == 32'h73 && rvfi[i].mode == 2'b11) ec = 1;
          end
        end
      end
      ok = (DEPTH - pre) >= grp.size();
      if (pre > 0 && ready) void'(q.pop_front());
      if (grp.size() > 0) begin
        if (ok) begin
          foreach (grp[j]) q.push_back(grp[j]);
          m_ret += nval;
        end else begin
          m_ovf = 1;
          m_drops = (m_drops + grp.size() > 65535) ? 65535 : m_drops + grp.size();
        end
      end
      if (m_run) begin
        if (ok && ec) begin
          m_run = 0; m_drain = 1;
        end else if (tmo_lim != 0 && m_cyc >= tmo_lim) begin
          m_run = 0; m_drain = 1; m_tmo = 1;
        end
      end else if (m_drain && pre == 0) begin
        m_drain = 0; m_halt = 1;
      end
      if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_ports();
    rvfi = '0;
  endtask

  task automatic do_clear();
    idle_ports();
    clear = 1'b1;
    step("clear");
    clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops;
    longint unsigned r0;
    trace_rec_t held;
    rvfi_instr_t ec_port;

    model_reset();
    #2;
    chk("reset level", level_o, 0);
    chk("reset valid", trace_valid_o, 0);
    chk("reset trace", trace_o, 0);
    chk("reset halt", halt_o, 0);
    chk("reset cycle", cycle_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    en = 1'b1;

    // 1: two commits per cycle with a ready sink
    ready = 1'b1;
    do_clear();
    r0 = m_ret; pops = 0;
    for (int c = 0; c < 4; c++) begin
      rvfi[0] = rnd_port(1, 0);
      rvfi[1] = rnd_port(1, 0);
      if (trace_valid_o && ready) pops++;
      step("t1 push");
    end
    idle_ports();
    for (int c = 0; c < 10; c++) begin
      if (trace_valid_o && ready) pops++;
      step("t1 drain");
    end
    chk("t1 pops", pops, 8);
    chk("t1 retired delta", retired_cnt_o - r0, 8);

    // 2: fill to DEPTH with a stalled sink, ninth group dropped
    ready = 1'b0;
    do_clear();
    for (int c = 0; c < 9; c++) begin
      rvfi[0] = rnd_port(1, 0);
      rvfi[1] = rnd_port(1, 0);
      step("t2 fill");
    end
    chk("t2 level", level_o, 16);
    chk("t2 drops", drop_cnt_o, 2);
    chk("t2 overflow", overflow_o, 1);

    // 3: trap on port0 plus valid on port1
    do_clear();
    r0 = m_ret;
    rvfi[0] = rnd_port(0, 1);
    rvfi[0].cause = 32'h2;
    rvfi[1] = rnd_port(1, 0);
    step("t3 push");
    idle_ports();
    chk("t3 level", level_o, 2);
    chk("t3 head trap", trace_o.trap, 1);
    chk("t3 head cause", trace_o.cause, 2);
    chk("t3 retired", retired_cnt_o, r0 + 1);
    ready = 1'b1;
    step("t3 pop");
    chk("t3 second trap", trace_o.trap, 0);
    ready = 1'b0;

    // 4: ECALL behind three queued records
    do_clear();
    r0 = m_ret;
    for (int c = 0; c < 3; c++) begin
      rvfi[0] = rnd_port(1, 0);
      rvfi[1] = '0;
      step("t4 queue");
    end
    ec_port = rnd_port(1, 0);
    ec_port.insn = 32'h0000_0073;
    ec_port.mode = 2'b11;
    rvfi[0] = ec_port;
    rvfi[1] = rnd_port(1, 0);
    step("t4 ecall");
    chk("t4 level", level_o, 4);
    chk("t4 retired", retired_cnt_o, r0 + 4);
    rvfi[0] = rnd_port(1, 0);
    rvfi[1] = rnd_port(1, 0);
    ready = 1'b1;
    for (int c = 0; c < 4; c++) step("t4 drain");
    chk("t4 empty", level_o, 0);
    chk("t4 halt early", halt_o, 0);
    step("t4 halt");
    chk("t4 halt", halt_o, 1);
    idle_ports();

    // 5: timeout with no commits, then clear
    do_clear();
    tmo_lim = 32'd100;
    for (int c = 0; c < 100; c++) step("t5 wait");
    chk("t5 no timeout yet", timeout_o, 0);
    step("t5 fire");
    chk("t5 cycle", cycle_o, 101);
    chk("t5 timeout", timeout_o, 1);
    step("t5 halt");
    chk("t5 halt", halt_o, 1);
    do_clear();
    tmo_lim = '0;
    chk("t5 clr cycle", cycle_o, 0);
    chk("t5 clr timeout", timeout_o, 0);
    chk("t5 clr halt", halt_o, 0);
    ready = 1'b0;
    rvfi[0] = rnd_port(1, 0);
    step("t5 run");
    chk("t5 capturing", level_o, 1);

    // 6: head stable under backpressure, then async reset
    idle_ports();
    held = q[0];
    for (int c = 0; c < 5; c++) begin
      step("t6 hold");
      chk("t6 stable", trace_o, held);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6 reset valid", trace_valid_o, 0);
    chk("t6 reset level", level_o, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    check_all("t6 post reset");

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      ready = ($urandom_range(0, 2) != 0);
      clear = ($urandom_range(0, 39) == 0);
      if (clear) tmo_lim = $urandom_range(0, 1) ? 32'($urandom_range(20, 80)) : 32'd0;
      for (int i = 0; i < NR; i++) begin
        case ($urandom_range(0, 5))
          0, 1:    rvfi[i] = '0;
          5:       rvfi[i] = rnd_port(0, 1);
          default: rvfi[i] = rnd_port(1, 0);
        endcase
      end
      if ($urandom_range(0, 59) == 0) begin
        rvfi[0] = rnd_port(1, 0);
        rvfi[0].insn = 32'h0000_0073;
        rvfi[0].mode = 2'b11;
      end
      step("rand");
    end
    clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
